// File: rtl/feature_weight_loader_if.sv
// Bundle of the loader's control, serial-input and memory-write signals.
//
// Parameters
//   KK : number of bits in one kernel word (KERNEL_SIZE*KERNEL_SIZE)
//   AW : width of the feature address
//
// Signals
//   start, abort        : sequence control from the configuration side
//   bit_in, bit_valid   : serial weight stream (producer side of the handshake)
//   bit_ready           : loader can accept a bit this cycle
//   address_w           : feature index presented to the weight memory
//   feature_WrEn        : active-low, single-cycle write strobe to the memory
//   weights_out[KK]     : assembled kernel, element i = i-th bit received
//   busy, done          : status
//
// Handshake: a bit moves on a rising clk edge exactly when bit_valid and
// bit_ready are both high during the cycle before that edge. bit_valid may be
// held, dropped or raised at any time; bit_ready never depends combinationally
// on bit_valid.
//
// Modports
//   master : drives the stream and the control inputs (configuration side)
//   slave  : the loader itself
interface feature_weight_loader_if #(
    parameter int KK = 9,
    parameter int AW = 5
);
    logic          start;
    logic          abort;
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic [AW-1:0] address_w;
    logic          feature_WrEn;
    logic          weights_out [KK];
    logic          busy;
    logic          done;

    modport master (
        output start, abort, bit_in, bit_valid,
        input  bit_ready, address_w, feature_WrEn, weights_out, busy, done
    );

    modport slave (
        input  start, abort, bit_in, bit_valid,
        output bit_ready, address_w, feature_WrEn, weights_out, busy, done
    );
endinterface

// File: rtl/feature_weight_loader.sv
// Serial-to-parallel writer for the feature weight memory.
//
// A 1-bit weight stream is deserialised into kernels of KERNEL_SIZE^2 bits.
// Each completed kernel is written with one active-low feature_WrEn pulse while
// address_w and weights_out are held stable, features 0..NUM_FEATURES-1 in order.
// After the last feature a one-cycle done pulse is produced.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst        : asynchronous, active-low reset
//   ifc        : feature_weight_loader_if.slave (control, stream, memory write)
//   state_dbg  : current FSM state (0 IDLE, 1 SHIFT, 2 WRITE, 3 DONE)
//
// Every output is a flop, so the memory (which samples on the falling edge)
// always sees values that settled half a cycle earlier.
module feature_weight_loader #(
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_FEATURES = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    feature_weight_loader_if.slave   ifc,
    output logic [1:0]               state_dbg
);
    localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int AW = $clog2(NUM_FEATURES) + 1;
    localparam int CW = $clog2(KK + 1);

    localparam logic [CW-1:0] LAST_BIT  = CW'(KK - 1);
    localparam logic [AW-1:0] LAST_FEAT = AW'(NUM_FEATURES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] bit_cnt;
    logic [AW-1:0] feat_cnt;
    logic          weights_q [KK];
    logic          wr_en_n_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          transfer;

    // bit_ready is exactly "state is SHIFT", so the state decode stands in for it.
    assign transfer = (state == S_SHIFT) && ifc.bit_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. abort overrides everything, including a
    // simultaneous start or a final-bit transfer.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (ifc.start) state_next = S_SHIFT;
            S_SHIFT: if (transfer && (bit_cnt == LAST_BIT)) state_next = S_WRITE;
            S_WRITE: state_next = (feat_cnt == LAST_FEAT) ? S_DONE : S_SHIFT;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (ifc.abort) state_next = S_IDLE;
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so they line up
    // with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_n_q <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_n_q <= (state_next != S_WRITE);
            ready_q   <= (state_next == S_SHIFT);
            busy_q    <= (state_next == S_SHIFT) || (state_next == S_WRITE);
            done_q    <= (state_next == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: bit/feature counters and the kernel shift register.
    // weights_q is never cleared between kernels; every element is
    // rewritten before the next WRITE anyway.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            feat_cnt <= '0;
            for (int i = 0; i < KK; i++) begin
                weights_q[i] <= 1'b0;
            end
        end else if (ifc.abort) begin
            // The bit offered alongside abort is discarded.
            bit_cnt  <= '0;
            feat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ifc.start) begin
                        bit_cnt  <= '0;
                        feat_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (ifc.bit_valid) begin
                        weights_q[bit_cnt] <= ifc.bit_in;
                        bit_cnt            <= bit_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    // feat_cnt stays at the last index through DONE so
                    // address_w never leaves the valid range.
                    if (feat_cnt != LAST_FEAT) begin
                        feat_cnt <= feat_cnt + 1'b1;
                        bit_cnt  <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ifc.bit_ready    = ready_q;
    assign ifc.feature_WrEn = wr_en_n_q;
    assign ifc.address_w    = feat_cnt;
    assign ifc.weights_out  = weights_q;
    assign ifc.busy         = busy_q;
    assign ifc.done         = done_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_feature_weight_loader.sv
// Bench for feature_weight_loader: randomized kernel streams, a scoreboard of
// expected memory writes, a falling-edge memory model and protocol checks.
module tb_feature_weight_loader;
    localparam int KS = 3;
    localparam int NF = 10;
    localparam int KK = KS * KS;
    localparam int AW = $clog2(NF) + 1;
    localparam int W  = AW + KK;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    feature_weight_loader_if #(.KK(KK), .AW(AW)) ifc ();

    feature_weight_loader #(
        .KERNEL_SIZE  (KS),
        .NUM_FEATURES (NF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ifc       (ifc),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q [$];
    logic [KK-1:0] golden     [NF];
    logic [KK-1:0] mem_model  [NF];
    int            vec_cnt    = 0;
    int            miscompares = 0;
    int            done_seen  = 0;
    int            done_exp   = 0;
    logic          prev_low   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [KK-1:0] pack_weights();
        logic [KK-1:0] v;
        for (int i = 0; i < KK; i++) v[i] = ifc.weights_out[i];
        return v;
    endfunction

    // ---------------- monitor (memory side, falling edge) ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (rst) begin
            if (!ifc.feature_WrEn) begin
                got = {ifc.address_w, pack_weights()};
                if (exp_q.size() == 0) begin
                    check("pending_writes", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp = exp_q.pop_front();
                    check("write_addr_kernel", 32'(got), 32'(exp));
                end
                if (ifc.address_w < AW'(NF)) mem_model[ifc.address_w] = pack_weights();
                else check("address_range", 32'(ifc.address_w), 32'(NF - 1));
                if (prev_low)      check("wren_pulse_width", 32'(prev_low), 32'd0);
                if (ifc.bit_ready) check("wren_with_ready", 32'(ifc.bit_ready), 32'd0);
                if (ifc.done)      check("wren_with_done", 32'(ifc.done), 32'd0);
            end
            prev_low = !ifc.feature_WrEn;
            if (ifc.done) done_seen++;
        end else begin
            prev_low = 1'b0;
        end
    end

    // ---------------- driver ----------------
    // pattern 0: (f+i)%2, 1: random, 2: (f+i+1)%2
    // stop_f/stop_b: when that many bits of feature stop_f have moved, abort
    // (stop_rst=0) or pulse reset (stop_rst=1); stop_f<0 runs the full load.
    task automatic run_load(input int stall_pct, input bit hold_start, input int pattern,
                            input int stop_f, input int stop_b, input bit stop_rst);
        int            f;
        int            b;
        int            cyc;
        int            n;
        logic          rdy;
        logic          v;
        logic          bv;
        logic [KK-1:0] kern;
        logic [AW-1:0] fa;

        for (int ff = 0; ff < NF; ff++) begin
            mem_model[ff] = '0;
            for (int i = 0; i < KK; i++) begin
                case (pattern)
                    0:       golden[ff][i] = 1'((ff + i) % 2);
                    2:       golden[ff][i] = 1'((ff + i + 1) % 2);
                    default: golden[ff][i] = 1'($urandom_range(0, 1));
                endcase
            end
        end

        @(posedge clk); #1;
        ifc.start     = 1'b1;
        ifc.bit_valid = 1'b0;
        @(posedge clk); #1;
        if (!hold_start) ifc.start = 1'b0;
        cyc = 1;
        check("start_to_ready", 32'(ifc.bit_ready), 32'd1);

        f    = 0;
        b    = 0;
        kern = '0;
        while (f < NF) begin
            if (cyc > 3000) begin
                check("load_cycle_budget", 32'(cyc), 32'd3000);
                break;
            end
            if (f == stop_f && b == stop_b) begin
                if (!stop_rst) begin
                    ifc.abort     = 1'b1;
                    ifc.bit_valid = 1'b1;
                    ifc.bit_in    = 1'b1;
                    @(posedge clk); #1;
                    ifc.abort     = 1'b0;
                    ifc.bit_valid = 1'b0;
                    check("abort_busy", 32'(ifc.busy), 32'd0);
                    check("abort_ready", 32'(ifc.bit_ready), 32'd0);
                    check("abort_state", 32'(state_dbg), 32'd0);
                    for (int k = 0; k < 12; k++) begin
                        @(posedge clk); #1;
                    end
                    check("abort_no_done", 32'(done_seen), 32'(done_exp));
                    check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
                end else begin
                    ifc.bit_valid = 1'b0;
                    #3;
                    rst = 1'b0;
                    #1;
                    check("rst_wren", 32'(ifc.feature_WrEn), 32'd1);
                    check("rst_busy", 32'(ifc.busy), 32'd0);
                    check("rst_ready", 32'(ifc.bit_ready), 32'd0);
                    check("rst_addr", 32'(ifc.address_w), 32'd0);
                    check("rst_weights", 32'(pack_weights()), 32'd0);
                    check("rst_queue_drained", 32'(exp_q.size()), 32'd0);
                    #3;
                    rst = 1'b1;
                    @(posedge clk); #1;
                end
                return;
            end

            rdy = ifc.bit_ready;
            v   = ($urandom_range(0, 99) >= stall_pct);
            // Outside SHIFT the bits are noise and must not be captured.
            bv  = rdy ? golden[f][b] : 1'($urandom_range(0, 1));
            ifc.bit_valid = v;
            ifc.bit_in    = bv;
            @(posedge clk); #1;
            cyc++;
            if (v && rdy) begin
                kern[b] = bv;
                b++;
                if (b == KK) begin
                    fa = f[AW-1:0];
                    exp_q.push_back({fa, kern});
                    f++;
                    b = 0;
                end
            end
        end
        ifc.bit_valid = 1'b0;

        // Last bit moved: one WRITE cycle, then DONE.
        n = 0;
        while (!ifc.done && n < 8) begin
            @(posedge clk); #1;
            cyc++;
            n++;
        end
        check("done_after_last_bit", 32'(n), 32'd1);
        // DONE is cycle NF*(KK+1)+1 counting the start-acceptance cycle as 0.
        if (stall_pct == 0) check("full_load_cycles", 32'(cyc), 32'(NF * (KK + 1) + 1));
        done_exp++;

        @(posedge clk); #1;
        ifc.start = 1'b0;
        check("idle_after_done_busy", 32'(ifc.busy), 32'd0);
        @(posedge clk); #1;
        check("no_restart_busy", 32'(ifc.busy), 32'd0);
        check("no_restart_ready", 32'(ifc.bit_ready), 32'd0);
        check("done_count", 32'(done_seen), 32'(done_exp));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int ff = 0; ff < NF; ff++) begin
            check($sformatf("mem_readback_%0d", ff), 32'(mem_model[ff]), 32'(golden[ff]));
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst           = 1'b0;
        ifc.start     = 1'b0;
        ifc.abort     = 1'b0;
        ifc.bit_in    = 1'b0;
        ifc.bit_valid = 1'b0;
        #23;
        check("reset_wren", 32'(ifc.feature_WrEn), 32'd1);
        check("reset_addr", 32'(ifc.address_w), 32'd0);
        check("reset_busy", 32'(ifc.busy), 32'd0);
        check("reset_done", 32'(ifc.done), 32'd0);
        check("reset_ready", 32'(ifc.bit_ready), 32'd0);
        check("reset_weights", 32'(pack_weights()), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-SHIFT of feature 1 (address 1, partial kernel held).
        run_load(0, 1'b0, 1, 1, 3, 1'b1);
        // Single kernel 1,0,1,... then abort during the following WRITE-side cycle.
        run_load(0, 1'b0, 2, 1, 0, 1'b0);
        // Full load, continuous valid.
        run_load(0, 1'b0, 0, -1, 0, 1'b0);
        // Same contents with ~50% stalls.
        run_load(50, 1'b0, 0, -1, 0, 1'b0);
        // Abort after feature 3 and 4 bits of feature 4, then a clean load.
        run_load(30, 1'b0, 1, 4, 4, 1'b0);
        run_load(0, 1'b0, 1, -1, 0, 1'b0);
        // start held high, noise bits driven in WRITE cycles.
        run_load(0, 1'b1, 1, -1, 0, 1'b0);
        run_load(20, 1'b1, 1, -1, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("final_done_count", 32'(done_seen), 32'(done_exp));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
